muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide unit with a 1-cycle multiply, a 33-cycle restoring divide and pipeline stall control.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  input  logic        mf_req_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t      state_q;
  logic        sgn_q, done_q;
  logic [5:0]  cnt_q;
  logic [31:0] rs_q, rt_q, quo_q, dvs_q, rem_q, hi_q, lo_q;
  logic [63:0] prod_d;
  logic [32:0] rem_sh, rem_sub;
  logic [31:0] rem_d, quo_d, quo_fix, rem_fix;
  logic        ge;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s & x[31]) ? -x : x;
  endfunction
  always_comb begin
    prod_d  = {sgn_q ? {32{rs_q[31]}} : 32'b0, rs_q} * {sgn_q ? {32{rt_q[31]}} : 32'b0, rt_q};
    rem_sh  = {rem_q, quo_q[31]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    ge      = ~rem_sub[32];
    rem_d   = ge ? rem_sub[31:0] : rem_sh[31:0];
    quo_d   = {quo_q[30:0], ge};
    quo_fix = (sgn_q & (rs_q[31] ^ rt_q[31])) ? -quo_q : quo_q;
    rem_fix = (sgn_q & rs_q[31]) ? -rem_q : rem_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rs_q    <= rs_i;
            rt_q    <= rt_i;
            sgn_q   <= ~op_i[0];
            quo_q   <= mag(rs_i, ~op_i[0]);
            dvs_q   <= mag(rt_i, ~op_i[0]);
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= op_i[1] ? DIV : MUL;
          end else begin
            if (mthi_i) hi_q <= wdata_i;
            if (mtlo_i) lo_q <= wdata_i;
          end
        end
        MUL: begin
          hi_q    <= prod_d[63:32];
          lo_q    <= prod_d[31:0];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        DIV: begin
          quo_q   <= quo_d;
          rem_q   <= rem_d;
          cnt_q   <= cnt_q + 6'd1;
          state_q <= (cnt_q == 6'd31) ? FIX : DIV;
        end
        FIX: begin
          // a zero divisor bypasses sign correction and reports all-ones / dividend
          lo_q    <= (rt_q == '0) ? 32'hFFFF_FFFF : quo_fix;
          hi_q    <= (rt_q == '0) ? rs_q : rem_fix;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != IDLE);
  assign stall_o = busy_o & (start_i | mthi_i | mtlo_i | mf_req_i);
endmodule
